fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RV32I core, directly upstream of decode and the immediate extender. Holds the PC and runs a single-outstanding request/response handshake to instruction memory. Latches each returned word into an instruction register and presents it with its PC to decode over a valid/ready handshake. Accepts branch/jump redirects from execute, where targets are computed as pc + imm_ext.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  32  fetch address; always equals pc.
- mem_ready  in  1  response valid; sampled only while mem_req=1.
- mem_rdata  in  32  instruction word; valid when mem_ready=1.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  32  fetched instruction word, fed to decode/imm extender.
- instr_pc  out  32  address of instr.
- redirect_valid  in  1  one-cycle redirect pulse from execute.
- redirect_target  in  32  new PC.
- fetch_fault  out  1  sticky; a misaligned redirect target was received.
- fetch_count  out  32  number of instructions accepted by decode.

## Operation
- Registers: pc, instr, instr_pc, state, fetch_count, fetch_fault.
- States:
  - START: mem_req=0; next cycle → FETCH.
  - FETCH: mem_req=1, mem_addr=pc; on mem_ready=1 → instr<=mem_rdata, instr_pc<=pc, → HOLD.
  - HOLD: instr_valid=1, mem_req=0; on instr_valid&instr_ready → pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), fetch_count<=fetch_count+1 (wraps), → FETCH.
  - FAULT: mem_req=0, instr_valid=0; exits only on reset.
- instr_valid=1 only in HOLD. Once asserted, instr/instr_pc stay stable until the handshake or a redirect.
- Redirect in any state except FAULT has priority over every other event in that cycle:
  - target[1:0]==0: pc<=target, instr_valid drops next cycle, → FETCH. A mem_ready in the same cycle is discarded (instr not updated). A decode handshake in the same cycle does not increment fetch_count or pc+4.
  - target[1:0]!=0: fetch_fault<=1, → FAULT, pc unchanged.
- Redirect in FAULT is ignored.
- mem_rdata is never inspected; any 32-bit word is passed through unchanged.

## Timing
- Reset (async assert, any state): state=START, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, fetch_fault=0, fetch_count=0.
- First mem_req is the 2nd rising edge after rst_n deasserts (START takes one cycle).
- Zero-wait memory (mem_ready high in the first FETCH cycle): instr_valid rises on the next edge. With instr_ready held high, throughput is one instruction per 2 cycles.
- N wait cycles add N cycles; mem_req and mem_addr stay constant while waiting.
- Redirect: mem_req at the target is asserted on the edge after the redirect cycle.
- Reset mid-fetch: the pending response is abandoned; memory must tolerate a dropped request.

## Test plan
- Reset/boot, RESET_PC=0x100, zero-wait memory, instr_ready=1:
  - All reset values as listed; first mem_addr=0x100 two cycles after rst_n rises.
  - Fetched words appear at instr_pc 0x100, 0x104, 0x108 at 2-cycle spacing; fetch_count=3.
- Backpressure: memory returns 0xFFF00013 at pc 0x0; instr_ready=0 for 5 cycles → instr/instr_pc held at 0xFFF00013/0x0, mem_req=0; on ready, pc→0x4, fetch_count=1.
- Wait states: mem_ready delayed 3 cycles for 0x0064A423 → mem_req high 4 cycles with mem_addr constant; instr_valid one edge after mem_ready.
- Redirect collision: in FETCH at pc 0x20, redirect_target=0x14 coincides with mem_ready → response dropped; next mem_addr=0x14; fetch_count unchanged. Repeat in HOLD with instr_ready=1 → no increment.
- Misaligned redirect: target 0x0A → fetch_fault=1, mem_req=0 forever; a later aligned redirect is ignored; only rst_n clears the fault.
- Wrap/async reset: RESET_PC=0xFFFF_FFFC → the fetch after the first accept is at 0x0. Asserting rst_n mid-wait returns all outputs to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with single-outstanding memory request
// Holds the PC, fetches one word at a time and hands it to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic        fetch_fault_o,
  output logic [31:0] fetch_count_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_START;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
      count_q    <= 32'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
    fault_d    = fault_q;

    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i) begin
          instr_d    = mem_rdata_i;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          pc_d    = pc_q + 32'd4;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FAULT;
    endcase

    // A redirect overrides whatever the state machine decided above, including
    // a response or decode handshake landing in the same cycle.
    if (redirect_valid_i && state_q != S_FAULT) begin
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      count_d    = count_q;
      if (redirect_target_i[1:0] == 2'b00) begin
        pc_d    = redirect_target_i;
        state_d = S_FETCH;
      end else begin
        pc_d    = pc_q;
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    end
  end

  assign mem_req_o     = (state_q == S_FETCH);
  assign mem_addr_o    = pc_q;
  assign instr_valid_o = (state_q == S_HOLD);
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign fetch_fault_o = fault_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        mem_req, mem_ready, instr_valid, instr_ready, redirect_valid, fetch_fault;
  logic [31:0] mem_addr, mem_rdata, instr, instr_pc, redirect_target, fetch_count;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc),
    .redirect_valid_i(redirect_valid), .redirect_target_i(redirect_target),
    .fetch_fault_o(fetch_fault), .fetch_count_o(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the fetch stage owes decode and memory, in transaction terms.
  bit          m_booted, m_waiting_mem, m_holding, m_dead;
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  bit          m_fault;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_booted = 0; m_waiting_mem = 0; m_holding = 0; m_dead = 0;
      m_pc = RPC; m_instr = 32'h13; m_ipc = RPC; m_cnt = 0; m_fault = 0;
    end else if (!m_dead && redirect_valid) begin
      m_booted = 1; m_holding = 0;
      if (redirect_target % 4 == 0) begin
        m_pc = redirect_target; m_waiting_mem = 1;
      end else begin
        m_fault = 1; m_dead = 1; m_waiting_mem = 0;
      end
    end else if (!m_dead) begin
      if (!m_booted) begin
        m_booted = 1; m_waiting_mem = 1;
      end else if (m_waiting_mem && mem_ready) begin
        m_instr = mem_rdata; m_ipc = m_pc; m_waiting_mem = 0; m_holding = 1;
      end else if (m_holding && instr_ready) begin
        m_pc = m_pc + 4; m_cnt = m_cnt + 1; m_holding = 0; m_waiting_mem = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_req", {31'd0, mem_req}, {31'd0, m_waiting_mem});
    chk("mem_addr", mem_addr, m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    chk("fetch_count", fetch_count, m_cnt);
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_addr"}, mem_addr, RPC);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_ipc"}, instr_pc, RPC);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    chk({tag, "_count"}, fetch_count, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1; redirect_target = t;
    cyc();
    redirect_valid = 0;
  endtask

  initial begin
    rst_n = 0; mem_ready = 0; mem_rdata = 0; instr_ready = 0;
    redirect_valid = 0; redirect_target = 0;
    repeat (2) cyc();
    chk_reset_vals("reset");

    // Boot with zero-wait memory and decode always ready
    mem_ready = 1; instr_ready = 1;
    rst_n = 1;
    cyc();
    chk("boot_req", {31'd0, mem_req}, 32'd1);
    chk("boot_addr", mem_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 32'hA000_0000 + i;
      cyc();
      chk("boot_valid", {31'd0, instr_valid}, 32'd1);
      chk("boot_ipc", instr_pc, 32'h100 + 4 * i);
      chk("boot_instr", instr, 32'hA000_0000 + i);
      cyc();
      chk("boot_next_addr", mem_addr, 32'h104 + 4 * i);
    end
    chk("boot_count", fetch_count, 32'd3);

    // Backpressure at pc 0
    mem_ready = 0; instr_ready = 0;
    redirect(32'h0);
    mem_ready = 1; mem_rdata = 32'hFFF0_0013;
    cyc();
    mem_ready = 0; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      chk("bp_instr", instr, 32'hFFF0_0013);
      chk("bp_ipc", instr_pc, 32'h0);
      chk("bp_req", {31'd0, mem_req}, 32'd0);
      cyc();
    end
    instr_ready = 1;
    cyc();
    instr_ready = 0;
    chk("bp_addr", mem_addr, 32'h4);
    chk("bp_count", fetch_count, 32'd4);

    // Three wait states at pc 4
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'd0, mem_req}, 32'd1);
      chk("ws_addr", mem_addr, 32'h4);
      cyc();
    end
    chk("ws_req4", {31'd0, mem_req}, 32'd1);
    mem_ready = 1; mem_rdata = 32'h0064_A423;
    cyc();
    mem_ready = 0;
    chk("ws_valid", {31'd0, instr_valid}, 32'd1);
    chk("ws_instr", instr, 32'h0064_A423);

    // Redirect colliding with a response, then with a decode handshake
    redirect(32'h20);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    redirect(32'h14);
    chk("col_addr", mem_addr, 32'h14);
    chk("col_instr", instr, 32'h0064_A423);
    chk("col_count", fetch_count, 32'd4);
    cyc();
    mem_ready = 0; instr_ready = 1;
    redirect(32'h20);
    chk("col2_count", fetch_count, 32'd4);
    chk("col2_addr", mem_addr, 32'h20);
    chk("col2_valid", {31'd0, instr_valid}, 32'd0);

    // PC wrap past the top of memory
    mem_ready = 1;
    redirect(32'hFFFF_FFFC);
    cyc();
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    cyc();
    chk("wrap_addr", mem_addr, 32'h0);

    // Misaligned redirect is sticky until reset
    redirect(32'h0000_000A);
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_addr", mem_addr, 32'h0);
    redirect(32'h40);
    repeat (3) cyc();
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_addr2", mem_addr, 32'h0);
    chk("mis_fault2", {31'd0, fetch_fault}, 32'd1);

    // Asynchronous reset in the middle of a wait
    rst_n = 0; cyc(); rst_n = 1; mem_ready = 0;
    repeat (3) cyc();
    chk("ar_req", {31'd0, mem_req}, 32'd1);
    #1 rst_n = 0;
    #1 chk_reset_vals("areset");
    cyc(); rst_n = 1;

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      mem_ready       = ($urandom_range(0, 1) == 1);
      mem_rdata       = $urandom;
      instr_ready     = ($urandom_range(0, 9) < 6);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = $urandom;
      if ($urandom_range(0, 7) != 0) redirect_target[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) redirect_target[31:2] = 30'h3FFF_FFFF;
      if ($urandom_range(0, 149) == 0) begin
        #1 rst_n = 0;
        #1 rst_n = 1;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
